// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a byte FIFO into asynchronous 8N1 (or 8E1 with UART_TX_PARITY_EN) frames on tx
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   fifo_empty FIFO empty flag
//   fifo_data  FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en one-cycle pop request
//   tx         serial line, idle high, registered
//   busy       high from the pop through the last stop-bit cycle
//   done       one-cycle pulse in the first idle cycle after the stop bit
//   Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, READ, LOAD, START, DATA, PARITY, STOP} state_t;
`ifdef UART_TX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
  logic par;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [2:0] bitn;
  logic [7:0] shift, shift_nxt;
  logic tx_nxt, bit_end;
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  assign fifo_rd_en = state == READ;
  assign busy = state != IDLE;
  always_comb begin
    nxt = state;
    shift_nxt = shift;
    case (state)
      IDLE:  nxt = fifo_empty ? IDLE : READ;
      READ:  nxt = LOAD;
      LOAD: begin
        nxt = START;
        shift_nxt = fifo_data;
      end
      START: nxt = bit_end ? DATA : START;
      DATA: if (bit_end) begin
        shift_nxt = shift >> 1;
        nxt = bitn == 3'd7 ? AFTER_DATA : DATA;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: nxt = bit_end ? STOP : PARITY;
`endif
      STOP:  nxt = bit_end ? IDLE : STOP;
      default: nxt = IDLE;
    endcase
    // tx is registered, so it is derived from where the FSM goes next
    tx_nxt = 1'b1;
    if (nxt == START) tx_nxt = 1'b0;
    if (nxt == DATA) tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
    if (nxt == PARITY) tx_nxt = par;
`endif
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
      bitn <= 3'd0;
      shift <= 8'h00;
      tx <= 1'b1;
      done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= nxt;
      shift <= shift_nxt;
      tx <= tx_nxt;
      done <= state == STOP && bit_end;
      // serial states only leave on bit_end, so clearing there also clears on every entry
      cnt <= (state inside {START, DATA, PARITY, STOP}) && !bit_end ? cnt + CW'(1) : '0;
      bitn <= state == LOAD ? 3'd0 : (state == DATA && bit_end) ? bitn + 3'd1 : bitn;
`ifdef UART_TX_PARITY_EN
      par <= state == LOAD ? ^fifo_data : par;
`endif
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench for fifo_uart_tx driven by a behavioural 4-deep FIFO
module tb_fifo_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 0, rstn = 1, fifo_empty, fifo_rd_en, tx, busy, done;
  logic [7:0] fifo_data = 8'h00;
  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic par;
  } vec_t;
  vec_t tv[9];
  int tests = 0, fails = 0, cyc = 0;
  logic [10:0] sb[$];
  logic [7:0] mem[4];
  logic [1:0] wp = 2'd0, rp = 2'd0;
  int fcnt = 0;
  logic push_v = 0, ovr_ne = 0;
  logic [7:0] push_d = 8'h00;
  assign fifo_empty = ovr_ne ? 1'b0 : (fcnt == 0);
  always @(posedge clk) begin
    cyc++;
    if (fifo_rd_en && fcnt > 0) begin
      fifo_data <= mem[rp];
      rp <= rp + 2'd1;
    end
    if (push_v && fcnt < 4) begin
      mem[wp] <= push_d;
      wp <= wp + 2'd1;
    end
    fcnt <= fcnt + ((push_v && fcnt < 4) ? 1 : 0) - ((fifo_rd_en && fcnt > 0) ? 1 : 0);
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  int mcnt = -1, rd_cnt = 0, done_cnt = 0, low_cnt = 0, rd_cyc = 0, done_cyc = 0, st_cyc = 0, prev_st = 0;
  logic [10:0] got, exp_f;
  logic stable, exp_done = 0;
  always @(negedge clk) begin
    if (!rstn) begin
      mcnt = -1;
      exp_done = 0;
    end else begin
      if (fifo_rd_en) begin
        rd_cnt++;
        rd_cyc = cyc;
      end
      if (exp_done) begin
        chk("done_after_stop", done, 1);
        exp_done = 0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!tx) low_cnt++;
      if (mcnt < 0 && !tx && busy) begin
        mcnt = 0;
        prev_st = st_cyc;
        st_cyc = cyc;
        got = '0;
        stable = 1;
      end
      if (mcnt >= 0) begin
        if (mcnt % CPB == 0) got[NB-1-mcnt/CPB] = tx;
        else if (tx !== got[NB-1-mcnt/CPB]) stable = 0;
        mcnt++;
        if (mcnt == NB * CPB) begin
          chk("bit_stable", stable, 1);
          chk("frame_expected", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            exp_f = sb.pop_front();
            chk("frame_bits", got, exp_f);
          end
          exp_done = 1;
          mcnt = -1;
        end
      end
    end
  end
  function automatic logic [10:0] expf(int i);
`ifdef UART_TX_PARITY_EN
    return {tv[i].frame[9:1], tv[i].par, tv[i].frame[0]};
`else
    return {1'b0, tv[i].frame};
`endif
  endfunction
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(int i);
    sb.push_back(expf(i));
    push_v = 1;
    push_d = tv[i].data;
    @(posedge clk);
    #1;
    push_v = 0;
  endtask
  task automatic wait_done(int target);
    for (int k = 0; k < 2000 && done_cnt < target; k++) tick(1);
    chk("done_reached", done_cnt >= target, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  int t0, d0, r0, l0;
  initial begin
    tv[0] = '{8'hA5, 10'b0101001011, 1'b0};
    tv[1] = '{8'h07, 10'b0111000001, 1'b1};
    tv[2] = '{8'h3C, 10'b0001111001, 1'b0};
    tv[3] = '{8'h00, 10'b0000000001, 1'b0};
    tv[4] = '{8'hFF, 10'b0111111111, 1'b0};
    tv[5] = '{8'h11, 10'b0100010001, 1'b0};
    tv[6] = '{8'h22, 10'b0010001001, 1'b0};
    tv[7] = '{8'h33, 10'b0110011001, 1'b0};
    tv[8] = '{8'h44, 10'b0001000101, 1'b0};
    #2 rstn = 0;
    ovr_ne = 1;
    tick(3);
    chk("rst_tx", tx, 1);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    ovr_ne = 0;
    tick(1);
    rstn = 1;
    r0 = rd_cnt;
    l0 = low_cnt;
    tick(50);
    chk("idle_no_rd", rd_cnt - r0, 0);
    chk("idle_tx_low_cycles", low_cnt - l0, 0);
    // single byte timing
    r0 = rd_cnt;
    d0 = done_cnt;
    push(0);
    t0 = cyc;
    wait_done(d0 + 1);
    chk("single_rd_pulses", rd_cnt - r0, 1);
    chk("single_rd_cycle", rd_cyc, t0 + 1);
    chk("single_tx_fall", st_cyc, t0 + 3);
    chk("single_done_cycle", done_cyc, st_cyc + NB * CPB);
    tick(2);
    // back-to-back
    d0 = done_cnt;
    push(3);
    push(4);
    wait_done(d0 + 2);
    chk("b2b_start_spacing", st_cyc - prev_st, NB * CPB + 3);
    chk("b2b_fifo_empty", fifo_empty, 1);
    tick(2);
    // preload a full FIFO while held in reset, then drain
    rstn = 0;
    for (int i = 5; i < 9; i++) push(i);
    chk("preload_full", fcnt, 4);
    r0 = rd_cnt;
    d0 = done_cnt;
    tick(1);
    rstn = 1;
    wait_done(d0 + 4);
    tick(2);
    chk("drain_rd_pulses", rd_cnt - r0, 4);
    chk("drain_done_pulses", done_cnt - d0, 4);
    chk("drain_fifo_empty", fifo_empty, 1);
    // reset during data bit 3 of 0x3C
    push(2);
    tick(3 + CPB + 3 * CPB + 1);
    chk("mid_busy_before", busy, 1);
    chk("mid_tx_bit3", tx, 1);
    #1 rstn = 0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    sb.delete();
    tick(1);
    push(1);
    tick(1);
    rstn = 1;
    t0 = cyc;
    d0 = done_cnt;
    wait_done(d0 + 1);
    chk("post_rst_tx_fall", st_cyc, t0 + 3);
    tick(2);
    // table sweep through the scoreboard
    for (int i = 0; i < 9; i++) begin
      d0 = done_cnt;
      push(i);
      wait_done(d0 + 1);
    end
    tick(5);
    chk("sb_drained", sb.size(), 0);
    chk("end_idle_tx", tx, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
